// File: rtl/click_report_scheduler_pkg.sv
// Shared cursor definitions: FSM encoding, button codes, fault tier and report payload.
package click_report_scheduler_pkg;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned BTN_W  = 2;
    localparam int unsigned AXIS_W = 8;
    localparam int unsigned TIER_W = 2;

    localparam logic [BTN_W-1:0]  BTN_NONE  = 2'b00;
    localparam logic [BTN_W-1:0]  BTN_LEFT  = 2'b01;
    localparam logic [BTN_W-1:0]  BTN_RIGHT = 2'b10;
    localparam logic [TIER_W-1:0] FAULT_TIER = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        HOLD,
        RELEASE,
        REFRACT
    } state_e;

    typedef struct packed {
        logic [BTN_W-1:0]  buttons;
        logic [AXIS_W-1:0] dx;
        logic [AXIS_W-1:0] dy;
    } report_t;

    function automatic logic is_fault(input logic [TIER_W-1:0] tier);
        return tier >= FAULT_TIER;
    endfunction

endpackage

// File: rtl/click_report_scheduler_if.sv
// Motion-offer and HID-report handshake bundle; master is the scheduler side.
interface click_report_scheduler_if;
    import click_report_scheduler_pkg::*;

    logic              mot_valid;
    logic [AXIS_W-1:0] mot_dx;
    logic [AXIS_W-1:0] mot_dy;
    logic              mot_ready;

    logic              rpt_valid;
    logic [BTN_W-1:0]  rpt_buttons;
    logic [AXIS_W-1:0] rpt_dx;
    logic [AXIS_W-1:0] rpt_dy;
    logic              rpt_ready;

    modport master (
        input  mot_valid, mot_dx, mot_dy, rpt_ready,
        output mot_ready, rpt_valid, rpt_buttons, rpt_dx, rpt_dy
    );

    modport slave (
        output mot_valid, mot_dx, mot_dy, rpt_ready,
        input  mot_ready, rpt_valid, rpt_buttons, rpt_dx, rpt_dy
    );

endinterface

// File: rtl/click_timer.sv
// Saturating 32-bit cycle counter shared by the HOLD and REFRACT phases.
module click_timer
    import click_report_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             count_en,
    input  logic [CNT_W-1:0] limit,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;

    // load zeroes the count; it saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (count_en && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign done_c = count_en && (count_q == limit);

endmodule

// File: rtl/click_report_scheduler.sv
// Turns dwell-detector click levels into press/release HID reports, interleaving
// motion reports only while no click sequence is in flight.
module click_report_scheduler
    import click_report_scheduler_pkg::*;
#(
    parameter int unsigned CLICK_HOLD_CYCLES = 2_000_000,
    parameter int unsigned REFRACT_CYCLES    = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  left_click,
    input  logic                  right_click,
    input  logic [TIER_W-1:0]     tier,
    click_report_scheduler_if.master bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CLICK_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REFRACT_LAST = CNT_W'(REFRACT_CYCLES - 1);

    state_e  state_q, state_d;
    report_t rpt_q;
    logic    rpt_valid_q;
    logic    run_q;
    logic    left_q, right_q;
    logic    pend_left_q, pend_right_q;

    logic             fault;
    logic             left_edge, right_edge, pend_any;
    logic             hs, mot_ready_c, mot_take;
    logic             load_press, load_release, clr_pend;
    logic             tmr_load, tmr_en, tmr_done_c;
    logic [CNT_W-1:0] tmr_limit;

    // run_q masks the first cycle after reset so a level already high is not an edge
    assign fault      = is_fault(tier);
    assign left_edge  = run_q && left_click  && !left_q;
    assign right_edge = run_q && right_click && !right_q;
    assign pend_any   = pend_left_q || pend_right_q;
    assign hs         = rpt_valid_q && bus.rpt_ready;

    assign mot_ready_c = run_q && !rpt_valid_q && !pend_any && !fault &&
                         ((state_q == IDLE) || (state_q == REFRACT));
    assign mot_take    = bus.mot_valid && mot_ready_c;

    assign tmr_en    = (state_q == HOLD) || (state_q == REFRACT);
    assign tmr_limit = (state_q == HOLD) ? HOLD_LAST : REFRACT_LAST;

    click_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .count_en (tmr_en),
        .limit    (tmr_limit),
        .done_c   (tmr_done_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a fault in HOLD forces the release so no button stays down
    always_comb begin
        state_d      = state_q;
        load_press   = 1'b0;
        load_release = 1'b0;
        clr_pend     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fault) begin
                    clr_pend = 1'b1;
                end else if (pend_any && !rpt_valid_q) begin
                    state_d    = PRESS;
                    load_press = 1'b1;
                end
            end
            PRESS: begin
                if (hs) state_d = HOLD;
            end
            HOLD: begin
                if (fault || tmr_done_c) begin
                    state_d      = RELEASE;
                    load_release = 1'b1;
                end
            end
            RELEASE: begin
                if (hs) state_d = REFRACT;
            end
            REFRACT: begin
                if (fault || tmr_done_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        tmr_load = (state_d != state_q) || fault;
    end

    // Click edge capture; only one click may be pending, left wins a tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            pend_left_q  <= 1'b0;
            pend_right_q <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            left_q  <= left_click;
            right_q <= right_click;
            if (clr_pend || load_press) begin
                pend_left_q  <= 1'b0;
                pend_right_q <= 1'b0;
            end else if ((state_q == IDLE) && !fault && !pend_any) begin
                if (left_edge) begin
                    pend_left_q <= 1'b1;
                end else if (right_edge) begin
                    pend_right_q <= 1'b1;
                end
            end
        end
    end

    // Report register: loads never collide with a handshake, payload frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q       <= '0;
            rpt_valid_q <= 1'b0;
        end else if (load_press) begin
            rpt_q       <= '{buttons: (pend_left_q ? BTN_LEFT : BTN_RIGHT), dx: '0, dy: '0};
            rpt_valid_q <= 1'b1;
        end else if (load_release) begin
            rpt_q       <= '{buttons: BTN_NONE, dx: '0, dy: '0};
            rpt_valid_q <= 1'b1;
        end else if (mot_take) begin
            rpt_q       <= '{buttons: BTN_NONE, dx: bus.mot_dx, dy: bus.mot_dy};
            rpt_valid_q <= 1'b1;
        end else if (hs) begin
            rpt_valid_q <= 1'b0;
        end
    end

    assign bus.mot_ready   = mot_ready_c;
    assign bus.rpt_valid   = rpt_valid_q;
    assign bus.rpt_buttons = rpt_q.buttons;
    assign bus.rpt_dx      = rpt_q.dx;
    assign bus.rpt_dy      = rpt_q.dy;

endmodule

// File: tb/tb_click_report_scheduler.sv
// Directed bench for click_report_scheduler with a report scoreboard and protocol rule checks.
`timescale 1ns/1ps
module tb_click_report_scheduler;

    localparam int unsigned HOLD = 4;
    localparam int unsigned REFR = 10;

    localparam logic [17:0] R_PRESS_L = {2'b01, 8'h00, 8'h00};
    localparam logic [17:0] R_REL     = {2'b00, 8'h00, 8'h00};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       left_click = 1'b0;
    logic       right_click = 1'b0;
    logic [1:0] tier = 2'd0;

    click_report_scheduler_if bus ();

    click_report_scheduler #(
        .CLICK_HOLD_CYCLES (HOLD),
        .REFRACT_CYCLES    (REFR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .left_click  (left_click),
        .right_click (right_click),
        .tier        (tier),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mot_acc = 0;
    int hs_cyc[$];
    logic [17:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [17:0] prev_pay;
    logic [17:0] cur_pay;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: reports must arrive in the expected order, stay frozen while stalled,
    // and motion must never be accepted while a report is pending or the tier is faulty.
    always @(negedge clk) begin
        #4;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            cur_pay = {bus.rpt_buttons, bus.rpt_dx, bus.rpt_dy};
            if (prev_stall) begin
                check("stall_valid", 32'(bus.rpt_valid), 32'd1);
                check("stall_payload", 32'(cur_pay), 32'(prev_pay));
            end
            if (bus.rpt_valid && bus.rpt_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_report: got %0h expected none (cycle %0d)", cur_pay, cyc);
                end else begin
                    check("report_payload", 32'(cur_pay), 32'(exp_q.pop_front()));
                end
                hs_cyc.push_back(cyc);
            end
            if (bus.rpt_valid || tier >= 2'd2) check("mot_ready_blocked", 32'(bus.mot_ready), 32'd0);
            if (bus.mot_valid && bus.mot_ready) mot_acc++;
            prev_stall = bus.rpt_valid && !bus.rpt_ready;
            prev_pay   = cur_pay;
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k = 0;
        while (hs_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("handshake_count", 32'(hs_cyc.size()), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, r, base, acc0;
        bus.mot_valid = 1'b0;
        bus.mot_dx    = 8'h00;
        bus.mot_dy    = 8'h00;
        bus.rpt_ready = 1'b1;

        // reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_rpt_valid", 32'(bus.rpt_valid), 32'd0);
        check("rst_rpt_buttons", 32'(bus.rpt_buttons), 32'd0);
        check("rst_rpt_dx", 32'(bus.rpt_dx), 32'd0);
        check("rst_rpt_dy", 32'(bus.rpt_dy), 32'd0);
        check("rst_mot_ready", 32'(bus.mot_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("mot_ready_first_cycle", 32'(bus.mot_ready), 32'd0);
        @(negedge clk);
        #1 check("mot_ready_idle", 32'(bus.mot_ready), 32'd1);
        @(negedge clk);

        // A: single left click, REFRACT boundary probed with right then left edges
        base = hs_cyc.size();
        exp_q.push_back(R_PRESS_L); exp_q.push_back(R_REL);
        exp_q.push_back(R_PRESS_L); exp_q.push_back(R_REL);
        c = cyc;
        left_click = 1'b1;
        @(negedge clk) left_click = 1'b0;
        wait_hs(base + 1, 20);
        check("press_latency", 32'(hs_cyc[base] - c), 32'd2);
        wait_hs(base + 2, 20);
        check("hold_gap", 32'(hs_cyc[base+1] - hs_cyc[base]), 32'(HOLD + 1));
        r = hs_cyc[base+1];
        at_cycle(r + REFR);
        right_click = 1'b1;
        at_cycle(r + REFR + 1);
        right_click = 1'b0;
        left_click  = 1'b1;
        @(negedge clk) left_click = 1'b0;
        wait_hs(base + 3, 30);
        check("refract_boundary", 32'(hs_cyc[base+2] - r), 32'(REFR + 3));
        wait_hs(base + 4, 20);
        check("hold_gap_2", 32'(hs_cyc[base+3] - hs_cyc[base+2]), 32'(HOLD + 1));
        repeat (REFR + 3) @(negedge clk);

        // B: simultaneous left and right edges
        base = hs_cyc.size();
        exp_q.push_back(R_PRESS_L); exp_q.push_back(R_REL);
        c = cyc;
        left_click  = 1'b1;
        right_click = 1'b1;
        @(negedge clk);
        left_click  = 1'b0;
        right_click = 1'b0;
        wait_hs(base + 2, 30);
        check("tie_press_latency", 32'(hs_cyc[base] - c), 32'd2);
        repeat (REFR + 3) @(negedge clk);

        // C: stalled motion report drains before a click arriving meanwhile
        base = hs_cyc.size();
        acc0 = mot_acc;
        exp_q.push_back({2'b00, 8'hFB, 8'h07});
        exp_q.push_back(R_PRESS_L); exp_q.push_back(R_REL);
        bus.rpt_ready = 1'b0;
        c = cyc;
        bus.mot_valid = 1'b1;
        bus.mot_dx    = 8'hFB;
        bus.mot_dy    = 8'h07;
        #1 check("mot_ready_offer", 32'(bus.mot_ready), 32'd1);
        @(negedge clk);
        bus.mot_valid = 1'b0;
        left_click    = 1'b1;
        #1 check("motion_dx", 32'(bus.rpt_dx), 32'h000000FB);
        @(negedge clk);
        left_click = 1'b0;
        #1 check("mot_ready_pending", 32'(bus.mot_ready), 32'd0);
        @(negedge clk);
        #1 check("motion_dy", 32'(bus.rpt_dy), 32'h00000007);
        at_cycle(c + 4);
        bus.rpt_ready = 1'b1;
        wait_hs(base + 1, 10);
        check("motion_hs_cycle", 32'(hs_cyc[base] - c), 32'd4);
        wait_hs(base + 2, 10);
        check("press_after_motion", 32'(hs_cyc[base+1] - hs_cyc[base]), 32'd2);
        check("motion_accepts", 32'(mot_acc - acc0), 32'd1);
        wait_hs(base + 3, 20);
        repeat (REFR + 3) @(negedge clk);

        // D: fault in HOLD forces immediate release; edges and motion ignored meanwhile
        base = hs_cyc.size();
        acc0 = mot_acc;
        exp_q.push_back(R_PRESS_L); exp_q.push_back(R_REL);
        c = cyc;
        left_click = 1'b1;
        @(negedge clk) left_click = 1'b0;
        at_cycle(c + 4);
        tier          = 2'd3;
        bus.mot_valid = 1'b1;
        bus.mot_dx    = 8'h01;
        bus.mot_dy    = 8'h01;
        #1 check("mot_ready_fault", 32'(bus.mot_ready), 32'd0);
        wait_hs(base + 2, 10);
        check("fault_release_cycle", 32'(hs_cyc[base+1] - c), 32'd5);
        at_cycle(c + 8);
        left_click = 1'b1;
        @(negedge clk) left_click = 1'b0;
        at_cycle(c + 12);
        tier          = 2'd0;
        bus.mot_valid = 1'b0;
        #1 check("fault_motion_accepts", 32'(mot_acc - acc0), 32'd0);
        @(negedge clk);
        #1 check("mot_ready_recovered", 32'(bus.mot_ready), 32'd1);
        repeat (REFR + 5) @(negedge clk);
        check("no_report_after_fault", 32'(hs_cyc.size()), 32'(base + 2));

        // E: reset mid-HOLD with left held high abandons the click
        base = hs_cyc.size();
        exp_q.push_back(R_PRESS_L);
        c = cyc;
        left_click = 1'b1;
        wait_hs(base + 1, 10);
        check("press_before_reset", 32'(hs_cyc[base] - c), 32'd2);
        at_cycle(c + 4);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rpt_valid", 32'(bus.rpt_valid), 32'd0);
        check("midrst_rpt_buttons", 32'(bus.rpt_buttons), 32'd0);
        check("midrst_rpt_dx", 32'(bus.rpt_dx), 32'd0);
        check("midrst_rpt_dy", 32'(bus.rpt_dy), 32'd0);
        check("midrst_mot_ready", 32'(bus.mot_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (HOLD + REFR + 5) @(negedge clk);
        check("no_report_after_reset", 32'(hs_cyc.size()), 32'(base + 1));
        left_click = 1'b0;
        @(negedge clk);
        exp_q.push_back({2'b00, 8'h03, 8'hFF});
        bus.mot_valid = 1'b1;
        bus.mot_dx    = 8'h03;
        bus.mot_dy    = 8'hFF;
        @(negedge clk) bus.mot_valid = 1'b0;
        wait_hs(base + 2, 10);
        repeat (3) @(negedge clk);

        check("expected_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
